mem_arbiter: RTL and testbench

Two-requester arbiter sharing one single-port memory between the instruction-fetch path and the load/store path of the pipelined core. It accepts one request at a time, forwards it to memory with a req/gnt/rvalid handshake and routes the response back to its owner. Data accesses have fixed priority, with a burst limit that bounds fetch starvation. It sits between the core's fetch/MEM stages and the unified memory model.

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/mem_arbiter.sv | 146 ++++++++++++++
 tb/tb_mem_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and default sizing for the fetch/load-store memory arbiter.
package mem_arb_pkg;

    localparam int unsigned ADDR_W_DEF      = 32;
    localparam int unsigned DATA_W_DEF      = 32;
    localparam int unsigned MAX_D_BURST_DEF = 4;
    localparam int unsigned BURST_CNT_W     = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_GNT = 2'd1,
        WAIT_RSP = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } arb_owner_e;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and load/store,
// one outstanding transaction at a time, data-first with a bounded burst.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W      = ADDR_W_DEF,
    parameter int unsigned DATA_W      = DATA_W_DEF,
    parameter int unsigned MAX_D_BURST = MAX_D_BURST_DEF
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                if_req_i,
    input  logic [ADDR_W-1:0]   if_addr_i,
    output logic                if_gnt_o,
    output logic                if_rvalid_o,
    output logic [DATA_W-1:0]   if_rdata_o,
    input  logic                d_req_i,
    input  logic [ADDR_W-1:0]   d_addr_i,
    input  logic                d_we_i,
    input  logic [DATA_W/8-1:0] d_be_i,
    input  logic [DATA_W-1:0]   d_wdata_i,
    output logic                d_gnt_o,
    output logic                d_rvalid_o,
    output logic [DATA_W-1:0]   d_rdata_o,
    output logic                mem_req_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic                mem_we_o,
    output logic [DATA_W/8-1:0] mem_be_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    input  logic                mem_gnt_i,
    input  logic                mem_rvalid_i,
    input  logic [DATA_W-1:0]   mem_rdata_i
);

    localparam int unsigned BE_W = DATA_W / 8;
    localparam logic [BURST_CNT_W-1:0] BURST_MAX = BURST_CNT_W'(MAX_D_BURST);

    arb_state_e               state_q;
    arb_owner_e               owner_q;
    logic [BURST_CNT_W-1:0]   burst_cnt_q;
    logic [BURST_CNT_W-1:0]   burst_cnt_d;
    logic                     mem_req_q;
    logic [ADDR_W-1:0]        addr_q;
    logic                     we_q;
    logic [BE_W-1:0]          be_q;
    logic [DATA_W-1:0]        wdata_q;

    logic                     fetch_due_s;
    logic                     sel_d_s;
    logic                     sel_if_s;
    logic                     rsp_s;

    // Grant selection: data wins unless a waiting fetch has exhausted the burst budget.
    always_comb begin
        fetch_due_s = if_req_i && (burst_cnt_q == BURST_MAX);
        sel_d_s     = (state_q == IDLE) && d_req_i && !fetch_due_s;
        sel_if_s    = (state_q == IDLE) && if_req_i && !sel_d_s;
        rsp_s       = (state_q == WAIT_RSP) && mem_rvalid_i;
    end

    // Burst counter tracks consecutive data grants taken while fetch was waiting.
    always_comb begin
        burst_cnt_d = burst_cnt_q;
        if (sel_if_s) begin
            burst_cnt_d = '0;
        end else if (sel_d_s) begin
            if (!if_req_i) begin
                burst_cnt_d = '0;
            end else if (burst_cnt_q != BURST_MAX) begin
                burst_cnt_d = burst_cnt_q + 4'd1;
            end else begin
                burst_cnt_d = burst_cnt_q;
            end
        end else begin
            burst_cnt_d = burst_cnt_q;
        end
    end

    // Transaction FSM with registered memory command; reset abandons any transaction.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            owner_q     <= OWN_IF;
            burst_cnt_q <= '0;
            mem_req_q   <= 1'b0;
            addr_q      <= '0;
            we_q        <= 1'b0;
            be_q        <= '0;
            wdata_q     <= '0;
        end else begin
            burst_cnt_q <= burst_cnt_d;
            case (state_q)
                IDLE: begin
                    if (sel_d_s) begin
                        state_q   <= WAIT_GNT;
                        owner_q   <= OWN_D;
                        mem_req_q <= 1'b1;
                        addr_q    <= d_addr_i;
                        we_q      <= d_we_i;
                        be_q      <= d_be_i;
                        wdata_q   <= d_wdata_i;
                    end else if (sel_if_s) begin
                        state_q   <= WAIT_GNT;
                        owner_q   <= OWN_IF;
                        mem_req_q <= 1'b1;
                        addr_q    <= if_addr_i;
                        we_q      <= 1'b0;
                        be_q      <= '1;
                        wdata_q   <= '0;
                    end
                end
                WAIT_GNT: begin
                    if (mem_gnt_i) begin
                        state_q   <= WAIT_RSP;
                        mem_req_q <= 1'b0;
                    end
                end
                WAIT_RSP: begin
                    if (mem_rvalid_i) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    // Response routing to the owner; rdata is forced to zero whenever rvalid is low.
    always_comb begin
        if_gnt_o    = sel_if_s;
        d_gnt_o     = sel_d_s;
        if_rvalid_o = rsp_s && (owner_q == OWN_IF);
        d_rvalid_o  = rsp_s && (owner_q == OWN_D);
        if_rdata_o  = if_rvalid_o ? mem_rdata_i : '0;
        d_rdata_o   = d_rvalid_o ? mem_rdata_i : '0;
        mem_req_o   = mem_req_q;
        mem_addr_o  = addr_q;
        mem_we_o    = we_q;
        mem_be_o    = be_q;
        mem_wdata_o = wdata_q;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, corner sequences,
// and a randomized run against a transaction-level reference model.
module tb_mem_arbiter;

    localparam int MAX = 4;

    logic        clk;
    logic        reset_n;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic        if_gnt_o;
    logic        if_rvalid_o;
    logic [31:0] if_rdata_o;
    logic        d_req_i;
    logic [31:0] d_addr_i;
    logic        d_we_i;
    logic [3:0]  d_be_i;
    logic [31:0] d_wdata_i;
    logic        d_gnt_o;
    logic        d_rvalid_o;
    logic [31:0] d_rdata_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;

    int checks = 0;
    int errors = 0;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_D_BURST(MAX)) dut (
        .clk(clk), .reset_n(reset_n),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
        .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
        .d_req_i(d_req_i), .d_addr_i(d_addr_i), .d_we_i(d_we_i), .d_be_i(d_be_i),
        .d_wdata_i(d_wdata_i), .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
        .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
        .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_idle();
        if_req_i = 1'b0; if_addr_i = 32'd0;
        d_req_i = 1'b0; d_addr_i = 32'd0; d_we_i = 1'b0; d_be_i = 4'd0; d_wdata_i = 32'd0;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'd0;
    endtask

    task automatic do_reset();
        drive_idle();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    function automatic logic any_out();
        return |{if_gnt_o, if_rvalid_o, if_rdata_o, d_gnt_o, d_rvalid_o, d_rdata_o,
                 mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o};
    endfunction

    typedef struct {
        logic        if_req;
        logic [31:0] if_addr;
        logic        d_req;
        logic        d_we;
        logic [31:0] d_addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          gnt_dly;
        int          rsp_dly;
        logic [31:0] rdata;
        logic        exp_if_gnt;
        logic        exp_d_gnt;
        logic [31:0] exp_addr;
        logic        exp_we;
        int          exp_rv_cyc;
        logic        exp_if_rv;
        logic [31:0] exp_rdata;
        logic        exp_next_if_gnt;
        logic        exp_next_d_gnt;
    } vec_t;

    function automatic vec_t mk(logic ir, logic [31:0] ia, logic dr, logic dw, logic [31:0] da,
                                logic [31:0] wd, logic [3:0] be, int gd, int rd, logic [31:0] rdat,
                                logic eig, logic edg, logic [31:0] ea, logic ew, int erc,
                                logic eirv, logic [31:0] erd, logic nig, logic ndg);
        vec_t v;
        v.if_req = ir; v.if_addr = ia; v.d_req = dr; v.d_we = dw; v.d_addr = da;
        v.wdata = wd; v.be = be; v.gnt_dly = gd; v.rsp_dly = rd; v.rdata = rdat;
        v.exp_if_gnt = eig; v.exp_d_gnt = edg; v.exp_addr = ea; v.exp_we = ew;
        v.exp_rv_cyc = erc; v.exp_if_rv = eirv; v.exp_rdata = erd;
        v.exp_next_if_gnt = nig; v.exp_next_d_gnt = ndg;
        return v;
    endfunction

    // Reference-model state for the random run: one transaction record plus memory contents.
    logic        m_busy, m_acc, m_owner_d, m_we;
    logic [31:0] m_addr, m_wdata, m_rsp_data;
    logic [3:0]  m_be;
    int          m_rsp_cnt, m_streak;
    logic [31:0] mem_model [logic [31:0]];
    bit          if_pend, d_pend;

    function automatic logic [31:0] mem_rd(logic [31:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return {a[15:0], 16'hA5A5};
    endfunction

    initial begin
        vec_t vecs[5];
        bit   exp_pat[10];
        bit   gseq[$];
        int   gcyc[$];
        logic [31:0] old_w;
        logic real_rv, eg_if, eg_d, rv_next;
        int   rv_cyc;
        logic rv_if;
        logic [31:0] rv_data, rv_other;

        vecs[0] = mk(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1, 1, 32'hDEADBEEF,
                     1'b1, 1'b0, 32'h100, 1'b0, 2, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
        vecs[1] = mk(1'b1, 32'h300, 1'b1, 1'b1, 32'h200, 32'h12345678, 4'hF, 1, 1, 32'h0,
                     1'b0, 1'b1, 32'h200, 1'b1, 2, 1'b0, 32'h0, 1'b1, 1'b0);
        vecs[2] = mk(1'b1, 32'h500, 1'b1, 1'b0, 32'h44, 32'h0, 4'h3, 6, 1, 32'hCAFEF00D,
                     1'b0, 1'b1, 32'h44, 1'b0, 7, 1'b0, 32'hCAFEF00D, 1'b1, 1'b0);
        vecs[3] = mk(1'b1, 32'h800, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 2, 3, 32'h0BADC0DE,
                     1'b1, 1'b0, 32'h800, 1'b0, 5, 1'b1, 32'h0BADC0DE, 1'b0, 1'b0);
        vecs[4] = mk(1'b0, 32'h0, 1'b1, 1'b0, 32'h10, 32'h0, 4'hF, 1, 4, 32'h55AA55AA,
                     1'b0, 1'b1, 32'h10, 1'b0, 5, 1'b0, 32'h55AA55AA, 1'b0, 1'b0);

        // Reset state, then spurious memory handshakes in IDLE with no requests.
        do_reset();
        #1 chk("reset_outputs", 32'(any_out()), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hFFFF0000 | 32'(i);
            #1 chk("idle_spurious", 32'(any_out()), 32'd0);
        end

        // Directed vector table: one full transaction each.
        foreach (vecs[n]) begin
            do_reset();
            @(posedge clk); #1;
            if_req_i = vecs[n].if_req; if_addr_i = vecs[n].if_addr;
            d_req_i = vecs[n].d_req; d_we_i = vecs[n].d_we; d_addr_i = vecs[n].d_addr;
            d_wdata_i = vecs[n].wdata; d_be_i = vecs[n].be;
            #1;
            chk("vec_gnt", 32'({if_gnt_o, d_gnt_o}), 32'({vecs[n].exp_if_gnt, vecs[n].exp_d_gnt}));
            chk("vec_req_at_accept", 32'(mem_req_o), 32'd0);
            rv_cyc = -1; rv_if = 1'b0; rv_data = 32'd0; rv_other = 32'd0;
            for (int k = 1; k <= 20; k++) begin
                @(posedge clk); #1;
                if_req_i = vecs[n].if_req && !vecs[n].exp_if_gnt;
                d_req_i = vecs[n].d_req && !vecs[n].exp_d_gnt;
                mem_gnt_i = (k == vecs[n].gnt_dly);
                mem_rvalid_i = (k == vecs[n].gnt_dly + vecs[n].rsp_dly);
                mem_rdata_i = mem_rvalid_i ? vecs[n].rdata : 32'hBAD0BAD0;
                #1;
                chk("vec_busy_gnt", 32'({if_gnt_o, d_gnt_o}), 32'd0);
                chk("vec_mem_req", 32'(mem_req_o), 32'(k <= vecs[n].gnt_dly));
                if (k <= vecs[n].gnt_dly) begin
                    chk("vec_mem_addr", mem_addr_o, vecs[n].exp_addr);
                    chk("vec_mem_we", 32'(mem_we_o), 32'(vecs[n].exp_we));
                    if (vecs[n].exp_we) begin
                        chk("vec_mem_wdata", mem_wdata_o, vecs[n].wdata);
                        chk("vec_mem_be", 32'(mem_be_o), 32'(vecs[n].be));
                    end
                end
                if (if_rvalid_o || d_rvalid_o) begin
                    rv_cyc = k; rv_if = if_rvalid_o;
                    rv_data = if_rvalid_o ? if_rdata_o : d_rdata_o;
                    rv_other = if_rvalid_o ? d_rdata_o : if_rdata_o;
                    break;
                end
            end
            chk("vec_rv_cycle", 32'(rv_cyc), 32'(vecs[n].exp_rv_cyc));
            chk("vec_rv_owner", 32'(rv_if), 32'(vecs[n].exp_if_rv));
            chk("vec_rdata_nonowner", rv_other, 32'd0);
            if (!vecs[n].exp_we) chk("vec_rdata", rv_data, vecs[n].exp_rdata);
            @(posedge clk); #1;
            mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'd0;
            #1 chk("vec_next_gnt", 32'({if_gnt_o, d_gnt_o}),
                   32'({vecs[n].exp_next_if_gnt, vecs[n].exp_next_d_gnt}));
        end

        // Burst limit: fetch and data both held; expect 4 data grants then one fetch, repeating.
        exp_pat = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        do_reset();
        rv_next = 1'b0;
        for (int c = 0; c < 60 && gseq.size() < 10; c++) begin
            @(posedge clk); #1;
            if_req_i = 1'b1; if_addr_i = 32'h900; d_req_i = 1'b1; d_addr_i = 32'h40;
            mem_gnt_i = mem_req_o; mem_rvalid_i = rv_next; mem_rdata_i = 32'h0;
            rv_next = mem_req_o;
            #1;
            if (if_gnt_o || d_gnt_o) begin
                chk("burst_one_gnt", 32'(if_gnt_o && d_gnt_o), 32'd0);
                gseq.push_back(if_gnt_o);
                gcyc.push_back(c);
            end
        end
        chk("burst_grant_count", 32'(gseq.size()), 32'd10);
        for (int i = 0; i < gseq.size() && i < 10; i++) begin
            chk("burst_order", 32'(gseq[i]), 32'(exp_pat[i]));
            if (i > 0) chk("burst_spacing", 32'(gcyc[i] - gcyc[i-1]), 32'd3);
        end

        // Reset in WAIT_RSP, stray response after release, then a normal access.
        do_reset();
        @(posedge clk); #1; if_req_i = 1'b1; if_addr_i = 32'h100;
        #1 chk("rst_seq_gnt", 32'(if_gnt_o), 32'd1);
        @(posedge clk); #1; if_req_i = 1'b0; mem_gnt_i = 1'b1;
        @(posedge clk); #1; mem_gnt_i = 1'b0;
        reset_n = 1'b0;
        #1 chk("rst_async_outputs", 32'(any_out()), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk); #1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h77777777;
        #1 chk("rst_stray_rvalid", 32'(any_out()), 32'd0);
        @(posedge clk); #1; mem_rvalid_i = 1'b0; d_req_i = 1'b1; d_addr_i = 32'h20;
        #1 chk("rst_after_gnt", 32'({if_gnt_o, d_gnt_o}), 32'b01);
        @(posedge clk); #1; d_req_i = 1'b0; mem_gnt_i = 1'b1;
        #1 chk("rst_after_req", 32'({mem_req_o, mem_addr_o[7:0]}), 32'h120);
        @(posedge clk); #1; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h13572468;
        #1 chk("rst_after_rsp", 32'({if_rvalid_o, d_rvalid_o}), 32'b01);
        chk("rst_after_rdata", d_rdata_o, 32'h13572468);

        // Randomized run against the transaction-level model.
        do_reset();
        m_busy = 1'b0; m_acc = 1'b0; m_owner_d = 1'b0; m_we = 1'b0; m_addr = 32'd0;
        m_wdata = 32'd0; m_be = 4'd0; m_rsp_data = 32'd0; m_rsp_cnt = 0; m_streak = 0;
        if_pend = 1'b0; d_pend = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            if (!if_pend) begin
                if_req_i = ($urandom_range(3) != 0);
                if_pend = if_req_i;
                if_addr_i = 32'($urandom_range(15)) << 2;
            end
            if (!d_pend) begin
                d_req_i = ($urandom_range(2) != 0);
                d_pend = d_req_i;
                d_addr_i = 32'($urandom_range(15)) << 2;
                d_we_i = $urandom_range(1) == 1;
                d_be_i = 4'($urandom_range(15));
                d_wdata_i = $urandom;
            end
            mem_gnt_i = ($urandom_range(2) != 0);
            real_rv = 1'b0;
            if (m_acc) begin
                m_rsp_cnt--;
                real_rv = (m_rsp_cnt == 0);
            end
            mem_rvalid_i = real_rv || (!m_acc && ($urandom_range(4) == 0));
            mem_rdata_i = real_rv ? m_rsp_data : $urandom;
            #1;
            eg_if = 1'b0; eg_d = 1'b0;
            if (!m_busy) begin
                if (d_pend && !(if_pend && m_streak == MAX)) eg_d = 1'b1;
                else if (if_pend) eg_if = 1'b1;
                else eg_if = 1'b0;
            end
            chk("rnd_gnt", 32'({if_gnt_o, d_gnt_o}), 32'({eg_if, eg_d}));
            chk("rnd_mem_req", 32'(mem_req_o), 32'(m_busy && !m_acc));
            if (m_busy && !m_acc) begin
                chk("rnd_mem_addr", mem_addr_o, m_addr);
                chk("rnd_mem_we", 32'(mem_we_o), 32'(m_we));
                if (m_we) chk("rnd_mem_wdata", mem_wdata_o & {{8{m_be[3]}}, {8{m_be[2]}}, {8{m_be[1]}}, {8{m_be[0]}}},
                              m_wdata & {{8{m_be[3]}}, {8{m_be[2]}}, {8{m_be[1]}}, {8{m_be[0]}}});
                if (mem_gnt_i) begin
                    m_acc = 1'b1;
                    m_rsp_cnt = $urandom_range(3, 1);
                    if (m_we) begin
                        old_w = mem_rd(m_addr);
                        for (int b = 0; b < 4; b++) if (m_be[b]) old_w[b*8 +: 8] = m_wdata[b*8 +: 8];
                        mem_model[m_addr] = old_w;
                        m_rsp_data = $urandom;
                    end else begin
                        m_rsp_data = mem_rd(m_addr);
                    end
                end
            end
            chk("rnd_if_rv", 32'(if_rvalid_o), 32'(real_rv && !m_owner_d));
            chk("rnd_d_rv", 32'(d_rvalid_o), 32'(real_rv && m_owner_d));
            chk("rnd_if_rdata", if_rdata_o, (real_rv && !m_owner_d) ? m_rsp_data : 32'd0);
            if (!(real_rv && m_owner_d && m_we))
                chk("rnd_d_rdata", d_rdata_o, (real_rv && m_owner_d) ? m_rsp_data : 32'd0);
            if (real_rv) begin
                m_busy = 1'b0; m_acc = 1'b0;
            end
            if (eg_d) begin
                m_busy = 1'b1; m_acc = 1'b0; m_owner_d = 1'b1;
                m_addr = d_addr_i; m_we = d_we_i; m_be = d_be_i; m_wdata = d_wdata_i;
                m_streak = if_pend ? ((m_streak < MAX) ? m_streak + 1 : MAX) : 0;
                d_pend = 1'b0;
            end
            if (eg_if) begin
                m_busy = 1'b1; m_acc = 1'b0; m_owner_d = 1'b0;
                m_addr = if_addr_i; m_we = 1'b0; m_be = 4'hF; m_wdata = 32'd0;
                m_streak = 0;
                if_pend = 1'b0;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
